reg_file_mp: RTL



---
 rtl/reg_file_mp_pkg.sv | 19 +
 rtl/reg_file_mp_if.sv | 36 +++
 rtl/reg_file_mp_scoreboard.sv | 67 ++++++
 rtl/reg_file_mp.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types, default parameters and bus-slicing helper for reg_file_mp.
package reg_file_mp_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam int unsigned DEF_REG_WIDTH  = 32;
  localparam int unsigned DEF_REG_DEPTH  = 32;
  localparam int unsigned DEF_NUM_RD     = 2;
  localparam int unsigned DEF_NUM_WD_SRC = 3;

  // Low bit of element idx in a packed bus of width-bit elements.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/claim bus of the register file. slave = register file side,
// master = pipeline side.
interface reg_file_mp_if
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  parameter int unsigned NUM_WD_SRC = DEF_NUM_WD_SRC
);
  localparam int unsigned AW = $clog2(REG_DEPTH);
  localparam int unsigned SW = $clog2(NUM_WD_SRC);

  logic                             o_Ready;
  logic                             i_Stall;
  logic [NUM_RD*AW-1:0]             i_RdAddr;
  logic [NUM_RD*REG_WIDTH-1:0]      o_RdData;
  logic [NUM_RD-1:0]                o_RdBusy;
  logic                             i_WE;
  logic [AW-1:0]                    i_WAddr;
  logic [SW-1:0]                    i_WDSrc;
  logic [NUM_WD_SRC*REG_WIDTH-1:0]  i_WD;
  logic                             i_ClaimEn;
  logic [AW-1:0]                    i_ClaimAddr;

  modport slave (
    input  i_Stall, i_RdAddr, i_WE, i_WAddr, i_WDSrc, i_WD, i_ClaimEn, i_ClaimAddr,
    output o_Ready, o_RdData, o_RdBusy
  );

  modport master (
    output i_Stall, i_RdAddr, i_WE, i_WAddr, i_WDSrc, i_WD, i_ClaimEn, i_ClaimAddr,
    input  o_Ready, o_RdData, o_RdBusy
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, claim beats clear,
// registered per-port lookups that hold while stalled. Entry 0 never busy.
module reg_file_mp_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned REG_DEPTH = DEF_REG_DEPTH,
  parameter int unsigned NUM_RD    = DEF_NUM_RD,
  localparam int unsigned AW       = $clog2(REG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 stall,
  input  logic                 claim_en,
  input  logic [AW-1:0]        claim_addr,
  input  logic                 clr_en,
  input  logic [AW-1:0]        clr_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD-1:0]    byp_hit,
  input  logic [NUM_RD-1:0]    byp_busy,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [REG_DEPTH-1:0] busy_q, busy_d;
  logic [NUM_RD-1:0]    rd_busy_q, rd_busy_d;
  logic [AW-1:0]        port_addr [NUM_RD];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_addr
    assign port_addr[k] = rd_addr[slice_lsb(k, AW) +: AW];
  end

  // Busy vector update: clear on write, then claim so a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en)   busy_d[clr_addr]   = 1'b0;
    if (claim_en) busy_d[claim_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Per-port lookup, held under stall, forced low outside RUN.
  always_comb begin
    rd_busy_d = rd_busy_q;
    if (!run) begin
      rd_busy_d = '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        if (byp_hit[k])              rd_busy_d[k] = byp_busy[k];
        else if (port_addr[k] == '0) rd_busy_d[k] = 1'b0;
        else                         rd_busy_d[k] = busy_q[port_addr[k]];
      end
    end
  end

  // Scoreboard state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      rd_busy_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_busy = rd_busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with post-reset clear sequencer, N-way write
// source mux and pending-write scoreboard. Register 0 reads as zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data/busy to
// reads; without it reads see the pre-write contents.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter int unsigned REG_DEPTH  = DEF_REG_DEPTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  parameter int unsigned NUM_WD_SRC = DEF_NUM_WD_SRC
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  reg_file_mp_if.slave  bus
);

  localparam int unsigned AW = $clog2(REG_DEPTH);
  localparam int unsigned SW = $clog2(NUM_WD_SRC);
  // One extra bit so the counter can reach REG_DEPTH, the "all cleared" mark.
  localparam int unsigned CW = AW + 1;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         ready_q, ready_d;
  logic [NUM_RD*REG_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [REG_WIDTH-1:0]         regs_q [REG_DEPTH];

  logic                  run;
  logic [REG_WIDTH-1:0]  wd_sel;
  logic                  src_ok;
  logic                  wr_clr;
  logic                  wr_ok;
  logic                  claim_ok;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic [AW-1:0]         rd_addr [NUM_RD];
  logic [NUM_RD-1:0]     byp_hit, byp_busy;

  assign run = (state_q == RUN);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_addr
    assign rd_addr[k] = bus.i_RdAddr[slice_lsb(k, AW) +: AW];
  end

  // Write-data source mux; an out-of-range select leaves src_ok low.
  always_comb begin
    wd_sel = '0;
    src_ok = 1'b0;
    for (int unsigned s = 0; s < NUM_WD_SRC; s++) begin
      if (bus.i_WDSrc == SW'(s)) begin
        wd_sel = bus.i_WD[slice_lsb(s, REG_WIDTH) +: REG_WIDTH];
        src_ok = 1'b1;
      end
    end
  end

  // A bad source still retires the pending write, so busy clears on wr_clr.
  assign wr_clr   = run && !i_Rst && bus.i_WE && (bus.i_WAddr != '0);
  assign wr_ok    = wr_clr && src_ok;
  assign claim_ok = run && !i_Rst && bus.i_ClaimEn && (bus.i_ClaimAddr != '0);

  // Single array write port shared by the clear sequencer and the pipeline.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (!i_Rst) begin
      if (state_q == CLEAR) begin
        mem_we    = (cnt_q < CW'(REG_DEPTH));
        mem_waddr = cnt_q[AW-1:0];
      end else if (wr_ok) begin
        mem_we    = 1'b1;
        mem_waddr = bus.i_WAddr;
        mem_wdata = wd_sel;
      end
    end
  end

  // Storage without reset so it can map onto block RAM.
  always_ff @(posedge i_Clk) begin
    if (mem_we) regs_q[mem_waddr] <= mem_wdata;
  end

`ifdef REGFILE_BYPASS_EN
  // Forward a same-cycle qualifying write; a same-address claim keeps busy set.
  always_comb begin
    byp_hit  = '0;
    byp_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      byp_hit[k]  = wr_ok && (rd_addr[k] == bus.i_WAddr);
      byp_busy[k] = claim_ok && (rd_addr[k] == bus.i_ClaimAddr);
    end
  end
`else
  assign byp_hit  = '0;
  assign byp_busy = '0;
`endif

  // Clear sequencer: one entry per cycle, RUN one edge after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      if (cnt_q == CW'(REG_DEPTH)) state_d = RUN;
      else                         cnt_d   = cnt_q + CW'(1);
    end
    ready_d = (state_d == RUN);
  end

  // Read data: zero outside RUN, held under stall, zero for address 0.
  always_comb begin
    rd_data_d = rd_data_q;
    if (!run) begin
      rd_data_d = '0;
    end else if (!bus.i_Stall) begin
      for (int unsigned k = 0; k < NUM_RD; k++) begin
        if (byp_hit[k])
          rd_data_d[slice_lsb(k, REG_WIDTH) +: REG_WIDTH] = wd_sel;
        else if (rd_addr[k] == '0)
          rd_data_d[slice_lsb(k, REG_WIDTH) +: REG_WIDTH] = '0;
        else
          rd_data_d[slice_lsb(k, REG_WIDTH) +: REG_WIDTH] = regs_q[rd_addr[k]];
      end
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rd_data_q <= rd_data_d;
    end
  end

  reg_file_mp_scoreboard #(
    .REG_DEPTH (REG_DEPTH),
    .NUM_RD    (NUM_RD)
  ) u_scoreboard (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .run        (run),
    .stall      (bus.i_Stall),
    .claim_en   (claim_ok),
    .claim_addr (bus.i_ClaimAddr),
    .clr_en     (wr_clr),
    .clr_addr   (bus.i_WAddr),
    .rd_addr    (bus.i_RdAddr),
    .byp_hit    (byp_hit),
    .byp_busy   (byp_busy),
    .rd_busy    (bus.o_RdBusy)
  );

  assign bus.o_Ready  = ready_q;
  assign bus.o_RdData = rd_data_q;

endmodule
